mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Upstream master for the data memory. Sits in the CPU MEM stage between pipeline and memory.
//  Turns a load/store request into one ena/w_r memory transaction:
//   - word address and byte-lane select;
//   - aligned write data;
//   - read-lane extraction with sign/zero extension.
//  Stalls the pipeline until the memory returns valid. Flags misaligned accesses and timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in REQ waiting for mem_valid_i before bus-error abort (>=2)
//  CNT_W           8    width of timeout counter; must hold TIMEOUT_CYCLES-1
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   reset, asynchronous, active-low
//  req_i           in   1   pipeline memory request valid
//  op_i            in   4   MEM_LB/LBU/LH/LHU/LW/SB/SH/SW (mem_defs.vh)
//  addr_i          in   32  byte address
//  wdata_i         in   32  store data, right-justified
//  rdata_o         out  32  extended load result, valid while done_o=1
//  done_o          out  1   1-cycle pulse: access finished (ok or error)
//  stall_o         out  1   hold pipeline (combinational)
//  exc_misalign_o  out  1   with done_o: alignment fault, no memory access made
//  exc_timeout_o   out  1   with done_o: memory did not answer in TIMEOUT_CYCLES
//  mem_ena_o       out  1   memory enable, held for whole transaction
//  mem_w_r_o       out  1   1=write, 0=read
//  mem_addr_o      out  32  word address = {2'b00, addr[31:2]}
//  mem_data_o      out  32  lane-replicated store data
//  mem_sel_o       out  4   byte-lane select, bit n = byte n (little-endian)
//  mem_data_i      in   32  memory read word
//  mem_valid_i     in   1   memory response; stays high while ena held, low after ena drops
//  mem_busy_i      in   1   memory busy; no new transaction is issued while high
// BEHAVIOUR
//  Reset (rst=0, any time): state IDLE, counter 0.
//   All outputs 0: rdata_o, done_o, exc_*, mem_ena_o, mem_w_r_o, mem_addr_o, mem_data_o, mem_sel_o.
//   A memory response in flight at reset is ignored.
//  FSM IDLE -> REQ -> DONE -> IDLE. Every mem_* output is registered.
//  IDLE:
//   - req_i=1, aligned, mem_busy_i=0: latch op/addr/data, drive mem_* on the next edge, go REQ.
//   - req_i=1, mem_busy_i=1: stay IDLE, stall_o=1.
//   - req_i=1, misaligned (LH/LHU/SH addr[0]!=0; LW/SW addr[1:0]!=0): go DONE, err=misalign.
//     mem_ena_o stays 0.
//  REQ:
//   - mem_ena_o=1; counter increments each cycle.
//   - mem_valid_i=1: capture mem_data_i, drop ena, go DONE.
//   - counter==TIMEOUT_CYCLES-1 and no valid: drop ena, go DONE, err=timeout.
//   - valid and terminal count in the same cycle: valid wins, no error.
//  DONE:
//   - done_o=1 for exactly one cycle; rdata_o and exc_* valid; mem_ena_o=0.
//   - Always returns to IDLE; req_i ignored this cycle.
//   - The dead cycle lets the memory clear valid before the next request.
//  stall_o = (IDLE & req_i) | REQ. It is 0 in DONE, so the pipeline advances on the DONE edge.
//  Latency: hit = 3 cycles from req_i to done_o (IDLE, REQ, DONE) when memory answers after 1 edge.
//  Lanes, b = addr[1:0]:
//   - SB: sel=1<<b, data={4{wdata[7:0]}}.
//   - SH: sel=addr[1]?4'b1100:4'b0011, data={2{wdata[15:0]}}.
//   - SW: sel=4'b1111.
//   - Loads use the same sel, with mem_w_r_o=0.
//  Loads:
//   - LB/LBU take byte b; LH/LHU take halfword addr[1].
//   - LB/LH sign-extend; LBU/LHU zero-extend.
//   - rdata_o=0 on stores and on errors.
//  mem_valid_i outside REQ is ignored. Undefined op_i is treated as a no-op: DONE with no access, no error.
// STRUCTURE
//  mem_defs.vh: op codes MEM_LB..MEM_SW, state encodings, lane-select constants.
//  Sub-module mem_lane_align (combinational): {op, addr[1:0], wdata, rdata_word} -> {sel, wdata_rep, rdata_ext}.
//  Top holds the FSM, timeout counter and output registers.
// TESTING
//  LW @0x4, memory answers 1 cycle after ena:
//   mem_addr_o=1, sel=1111; done_o 3 cycles after req_i; rdata_o=mem word; stall_o low only in DONE.
//  SB 0xA5 @0x6:
//   sel=0100, mem_data_o=0xA5A5A5A5, mem_w_r_o=1; done_o pulses, no exceptions.
//  LB/LBU @0x3 with word 0x80FF7F01:
//   LB -> 0xFFFFFF80; LBU -> 0x00000080; LH @0x2 -> 0xFFFF80FF.
//  LW @0x2:
//   no mem_ena_o; next cycle done_o=1, exc_misalign_o=1, rdata_o=0.
//  TIMEOUT_CYCLES=4, valid never rises:
//   ena high 4 cycles, then done_o+exc_timeout_o; valid on the terminal cycle gives a normal completion.
//  Reset asserted mid-REQ:
//   all outputs 0 immediately; a late mem_valid_i gives no done_o; the next req_i completes normally.
//   mem_busy_i=1 for 5 cycles delays ena by 5 with stall_o held.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage memory access controller:
// op codes, FSM states, lane-select constants and op classification helpers.
package mem_access_ctrl_pkg;

  typedef enum logic [3:0] {
    MEM_LB  = 4'h0,
    MEM_LBU = 4'h1,
    MEM_LH  = 4'h2,
    MEM_LHU = 4'h3,
    MEM_LW  = 4'h4,
    MEM_SB  = 4'h8,
    MEM_SH  = 4'h9,
    MEM_SW  = 4'hA
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] SEL_NONE    = 4'b0000;
  localparam logic [3:0] SEL_BYTE0   = 4'b0001;
  localparam logic [3:0] SEL_LO_HALF = 4'b0011;
  localparam logic [3:0] SEL_HI_HALF = 4'b1100;
  localparam logic [3:0] SEL_WORD    = 4'b1111;

  function automatic logic is_load(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: is_load = 1'b1;
      default:                                  is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    case (op)
      MEM_SB, MEM_SH, MEM_SW: is_store = 1'b1;
      default:                is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] byte_off);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: is_misaligned = byte_off[0];
      MEM_LW, MEM_SW:          is_misaligned = |byte_off;
      default:                 is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational byte-lane logic: store lane select and replication,
// load lane extraction with sign or zero extension.
module mem_access_ctrl_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte     = rdata_word[{byte_off, 3'b000} +: 8];
    rhalf     = byte_off[1] ? rdata_word[31:16] : rdata_word[15:0];
    sel       = SEL_NONE;
    wdata_rep = '0;
    rdata_ext = '0;

    case (op)
      MEM_LB, MEM_LBU, MEM_SB: sel = SEL_BYTE0 << byte_off;
      MEM_LH, MEM_LHU, MEM_SH: sel = byte_off[1] ? SEL_HI_HALF : SEL_LO_HALF;
      MEM_LW, MEM_SW:          sel = SEL_WORD;
      default:                 sel = SEL_NONE;
    endcase

    // Stores are replicated across lanes so the memory just honours sel.
    case (op)
      MEM_SB:  wdata_rep = {4{wdata[7:0]}};
      MEM_SH:  wdata_rep = {2{wdata[15:0]}};
      MEM_SW:  wdata_rep = wdata;
      default: wdata_rep = '0;
    endcase

    case (op)
      MEM_LB:  rdata_ext = {{24{rbyte[7]}}, rbyte};
      MEM_LBU: rdata_ext = {24'h0, rbyte};
      MEM_LH:  rdata_ext = {{16{rhalf[15]}}, rhalf};
      MEM_LHU: rdata_ext = {16'h0, rhalf};
      MEM_LW:  rdata_ext = rdata_word;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory master: one registered ena/w_r transaction per load/store,
// pipeline stall until completion, misalignment and timeout reporting.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        stall_o,
  output logic        exc_misalign_o,
  output logic        exc_timeout_o,
  output logic        mem_ena_o,
  output logic        mem_w_r_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_sel_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_valid_i,
  input  logic        mem_busy_i
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       op_reg;
  logic [1:0]       off_reg;

  logic             launch, capture, fin_misalign, fin_timeout;
  logic [3:0]       align_op;
  logic [1:0]       align_off;
  logic [3:0]       align_sel;
  logic [31:0]      align_wdata, align_rdata;

  // In IDLE the aligner prepares the outgoing lanes; in REQ it decodes the reply.
  assign align_op  = (state_reg == ST_IDLE) ? op_i : op_reg;
  assign align_off = (state_reg == ST_IDLE) ? addr_i[1:0] : off_reg;

  mem_access_ctrl_lane_align u_lane_align (
    .op         (align_op),
    .byte_off   (align_off),
    .wdata      (wdata_i),
    .rdata_word (mem_data_i),
    .sel        (align_sel),
    .wdata_rep  (align_wdata),
    .rdata_ext  (align_rdata)
  );

  always_comb begin
    state_next   = state_reg;
    stall_o      = 1'b0;
    launch       = 1'b0;
    capture      = 1'b0;
    fin_misalign = 1'b0;
    fin_timeout  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_i) begin
          stall_o = 1'b1;
          // Bad ops and misaligned accesses finish without touching memory.
          if (!is_load(op_i) && !is_store(op_i)) begin
            state_next = ST_DONE;
          end else if (is_misaligned(op_i, addr_i[1:0])) begin
            state_next   = ST_DONE;
            fin_misalign = 1'b1;
          end else if (!mem_busy_i) begin
            state_next = ST_REQ;
            launch     = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall_o = 1'b1;
        if (mem_valid_i) begin
          state_next = ST_DONE;
          capture    = 1'b1;
        end else if (cnt_reg == CNT_TERM) begin
          state_next  = ST_DONE;
          fin_timeout = 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      op_reg         <= '0;
      off_reg        <= '0;
      rdata_o        <= '0;
      done_o         <= 1'b0;
      exc_misalign_o <= 1'b0;
      exc_timeout_o  <= 1'b0;
      mem_ena_o      <= 1'b0;
      mem_w_r_o      <= 1'b0;
      mem_addr_o     <= '0;
      mem_data_o     <= '0;
      mem_sel_o      <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= (state_reg == ST_REQ && state_next == ST_REQ) ? cnt_reg + CNT_W'(1) : '0;
      done_o         <= (state_next == ST_DONE);
      exc_misalign_o <= fin_misalign;
      exc_timeout_o  <= fin_timeout;
      rdata_o        <= capture ? align_rdata : '0;
      if (launch) begin
        op_reg     <= op_i;
        off_reg    <= addr_i[1:0];
        mem_ena_o  <= 1'b1;
        mem_w_r_o  <= is_store(op_i);
        mem_addr_o <= {2'b00, addr_i[31:2]};
        mem_sel_o  <= align_sel;
        mem_data_o <= align_wdata;
      end else if (state_next != ST_REQ) begin
        mem_ena_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (timeout shortened to 4 cycles).
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic        mem_valid = 1'b0, mem_busy = 1'b0;
  logic [31:0] rdata_o, mem_addr_o, mem_data_o;
  logic        done_o, stall_o, exc_misalign_o, exc_timeout_o, mem_ena_o, mem_w_r_o;
  logic [3:0]  mem_sel_o;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_i(req), .op_i(op), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata_o), .done_o(done_o), .stall_o(stall_o),
    .exc_misalign_o(exc_misalign_o), .exc_timeout_o(exc_timeout_o),
    .mem_ena_o(mem_ena_o), .mem_w_r_o(mem_w_r_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_sel_o(mem_sel_o),
    .mem_data_i(mem_rdata), .mem_valid_i(mem_valid), .mem_busy_i(mem_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request; memory raises valid once ena has been seen for more than lat edges.
  task automatic do_access(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w,
                           input logic [31:0] word, input int lat,
                           output int cycles, output int ena_cnt, output logic [3:0] sel_seen,
                           output logic [31:0] addr_seen, output logic [31:0] data_seen,
                           output logic wr_seen, output logic stall_ok,
                           output logic [31:0] rd, output logic [2:0] flags);
    req = 1'b1; op = o; addr = a; wdata = w;
    cycles = 0; ena_cnt = 0; sel_seen = '0; addr_seen = '0; data_seen = '0; wr_seen = 1'b0;
    #1;
    stall_ok = stall_o;
    while (!done_o && cycles < 20) begin
      tick();
      cycles++;
      if (done_o) stall_ok = stall_ok & ~stall_o;
      else        stall_ok = stall_ok & stall_o;
      if (mem_ena_o) begin
        if (ena_cnt == 0) begin
          sel_seen = mem_sel_o; addr_seen = mem_addr_o; data_seen = mem_data_o; wr_seen = mem_w_r_o;
        end
        ena_cnt++;
        if (ena_cnt > lat) begin
          mem_valid = 1'b1; mem_rdata = word;
        end
      end
    end
    rd = rdata_o;
    flags = {done_o, exc_misalign_o, exc_timeout_o};
    $display("txn op=%h addr=%h cycles=%0d ena=%0d sel=%b rdata=%h flags=%b",
             o, a, cycles, ena_cnt, sel_seen, rd, flags);
    req = 1'b0; mem_valid = 1'b0;
    tick();
  endtask

  int          cyc, ecnt;
  logic [3:0]  sel_s;
  logic [31:0] addr_s, data_s, rd_s;
  logic        wr_s, stall_s;
  logic [2:0]  fl_s;

  task automatic test_reset();
    tick(); tick();
    n_cmp++;
    if ({rdata_o, done_o, exc_misalign_o, exc_timeout_o, mem_ena_o, mem_w_r_o,
         mem_addr_o, mem_data_o, mem_sel_o, stall_o} !== '0) begin
      $display("FAIL reset_outputs: got rdata=%h done=%b ena=%b addr=%h data=%h sel=%b stall=%b, want all 0",
               rdata_o, done_o, mem_ena_o, mem_addr_o, mem_data_o, mem_sel_o, stall_o);
      n_bad++;
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({done_o, mem_ena_o, stall_o} !== 3'b000) begin
      $display("FAIL reset_release: got done/ena/stall=%b want 000", {done_o, mem_ena_o, stall_o});
      n_bad++;
    end
  endtask

  task automatic test_lw();
    do_access(MEM_LW, 32'h4, 32'h0, 32'hDEADBEEF, 1, cyc, ecnt, sel_s, addr_s, data_s, wr_s, stall_s, rd_s, fl_s);
    n_cmp++; if (addr_s !== 32'h1) begin $display("FAIL lw_addr: got %h want 00000001", addr_s); n_bad++; end
    n_cmp++; if (sel_s !== 4'b1111 || wr_s !== 1'b0) begin $display("FAIL lw_sel_wr: got %b/%b want 1111/0", sel_s, wr_s); n_bad++; end
    n_cmp++; if (cyc != 3) begin $display("FAIL lw_latency: got %0d want 3", cyc); n_bad++; end
    n_cmp++; if (rd_s !== 32'hDEADBEEF || fl_s !== 3'b100) begin $display("FAIL lw_result: got %h/%b want deadbeef/100", rd_s, fl_s); n_bad++; end
    n_cmp++; if (stall_s !== 1'b1) begin $display("FAIL lw_stall: got %b want 1 (stall low only in DONE)", stall_s); n_bad++; end
    n_cmp++; if (done_o !== 1'b0) begin $display("FAIL lw_done_pulse: got %b want 0 after DONE", done_o); n_bad++; end
  endtask

  task automatic test_sb();
    do_access(MEM_SB, 32'h6, 32'h000000A5, 32'h12345678, 1, cyc, ecnt, sel_s, addr_s, data_s, wr_s, stall_s, rd_s, fl_s);
    n_cmp++; if (sel_s !== 4'b0100 || wr_s !== 1'b1 || addr_s !== 32'h1) begin
      $display("FAIL sb_lanes: got sel=%b wr=%b addr=%h want 0100/1/00000001", sel_s, wr_s, addr_s); n_bad++; end
    n_cmp++; if (data_s !== 32'hA5A5A5A5) begin $display("FAIL sb_data: got %h want a5a5a5a5", data_s); n_bad++; end
    n_cmp++; if (fl_s !== 3'b100 || rd_s !== 32'h0) begin $display("FAIL sb_done: got %b/%h want 100/00000000", fl_s, rd_s); n_bad++; end
  endtask

  task automatic test_sh_sw();
    do_access(MEM_SH, 32'h12, 32'hFFFF1234, 32'h0, 0, cyc, ecnt, sel_s, addr_s, data_s, wr_s, stall_s, rd_s, fl_s);
    n_cmp++; if ({sel_s, data_s, addr_s} !== {4'b1100, 32'h12341234, 32'h4}) begin
      $display("FAIL sh_lanes: got sel=%b data=%h addr=%h want 1100/12341234/00000004", sel_s, data_s, addr_s); n_bad++; end
    do_access(MEM_SW, 32'h20, 32'hCAFEF00D, 32'h0, 0, cyc, ecnt, sel_s, addr_s, data_s, wr_s, stall_s, rd_s, fl_s);
    n_cmp++; if ({sel_s, data_s, wr_s, cyc} !== {4'b1111, 32'hCAFEF00D, 1'b1, 32'd2}) begin
      $display("FAIL sw_lanes: got sel=%b data=%h wr=%b cycles=%0d want 1111/cafef00d/1/2", sel_s, data_s, wr_s, cyc); n_bad++; end
  endtask

  task automatic test_loads();
    logic [3:0]  ops  [5] = '{MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LB};
    logic [31:0] adrs [5] = '{32'h3, 32'h3, 32'h2, 32'h2, 32'h1};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h0000007F};
    logic [3:0]  sels [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      do_access(ops[i], adrs[i], 32'h0, 32'h80FF7F01, 1, cyc, ecnt, sel_s, addr_s, data_s, wr_s, stall_s, rd_s, fl_s);
      n_cmp++;
      if (rd_s !== exps[i] || sel_s !== sels[i] || fl_s !== 3'b100) begin
        $display("FAIL load_%0d: got rdata=%h sel=%b flags=%b want %h/%b/100", i, rd_s, sel_s, fl_s, exps[i], sels[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_misalign_noop();
    do_access(MEM_LW, 32'h2, 32'h0, 32'h11111111, 0, cyc, ecnt, sel_s, addr_s, data_s, wr_s, stall_s, rd_s, fl_s);
    n_cmp++; if (ecnt != 0 || cyc != 1) begin $display("FAIL lw_misalign_access: got ena=%0d cycles=%0d want 0/1", ecnt, cyc); n_bad++; end
    n_cmp++; if (fl_s !== 3'b110 || rd_s !== 32'h0) begin $display("FAIL lw_misalign_flags: got %b/%h want 110/00000000", fl_s, rd_s); n_bad++; end
    do_access(MEM_SH, 32'h5, 32'h0, 32'h0, 0, cyc, ecnt, sel_s, addr_s, data_s, wr_s, stall_s, rd_s, fl_s);
    n_cmp++; if (fl_s !== 3'b110 || ecnt != 0) begin $display("FAIL sh_misalign: got %b ena=%0d want 110/0", fl_s, ecnt); n_bad++; end
    do_access(4'h7, 32'h0, 32'h0, 32'h0, 0, cyc, ecnt, sel_s, addr_s, data_s, wr_s, stall_s, rd_s, fl_s);
    n_cmp++; if (fl_s !== 3'b100 || ecnt != 0 || cyc != 1) begin
      $display("FAIL noop: got flags=%b ena=%0d cycles=%0d want 100/0/1", fl_s, ecnt, cyc); n_bad++; end
  endtask

  task automatic test_timeout();
    do_access(MEM_LW, 32'h8, 32'h0, 32'h55AA55AA, 99, cyc, ecnt, sel_s, addr_s, data_s, wr_s, stall_s, rd_s, fl_s);
    n_cmp++; if (ecnt != 4 || cyc != 5) begin $display("FAIL timeout_len: got ena=%0d cycles=%0d want 4/5", ecnt, cyc); n_bad++; end
    n_cmp++; if (fl_s !== 3'b101 || rd_s !== 32'h0) begin $display("FAIL timeout_flags: got %b/%h want 101/00000000", fl_s, rd_s); n_bad++; end
    do_access(MEM_LW, 32'h8, 32'h0, 32'h55AA55AA, 3, cyc, ecnt, sel_s, addr_s, data_s, wr_s, stall_s, rd_s, fl_s);
    n_cmp++; if (fl_s !== 3'b100 || rd_s !== 32'h55AA55AA || ecnt != 4) begin
      $display("FAIL timeout_terminal_valid: got %b/%h ena=%0d want 100/55aa55aa/4", fl_s, rd_s, ecnt); n_bad++; end
  endtask

  task automatic test_busy();
    logic bad = 1'b0;
    mem_busy = 1'b1; req = 1'b1; op = MEM_LW; addr = 32'hC;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_ena_o !== 1'b0 || stall_o !== 1'b1) bad = 1'b1;
    end
    mem_busy = 1'b0;
    n_cmp++; if (bad) begin $display("FAIL busy_hold: got ena high or stall low while busy, want ena 0 stall 1"); n_bad++; end
    tick();
    n_cmp++; if (mem_ena_o !== 1'b1 || mem_addr_o !== 32'h3) begin
      $display("FAIL busy_launch: got ena=%b addr=%h want 1/00000003", mem_ena_o, mem_addr_o); n_bad++; end
    mem_valid = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    n_cmp++; if (done_o !== 1'b1 || rdata_o !== 32'h0BADF00D) begin
      $display("FAIL busy_done: got done=%b rdata=%h want 1/0badf00d", done_o, rdata_o); n_bad++; end
    $display("txn busy LW addr=0000000c rdata=%h", rdata_o);
    req = 1'b0; mem_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic got_done = 1'b0;
    req = 1'b1; op = MEM_SW; addr = 32'h10; wdata = 32'h01020304;
    tick();
    #2;
    rst = 1'b0; req = 1'b0;
    #1;
    n_cmp++;
    if ({rdata_o, done_o, exc_misalign_o, exc_timeout_o, mem_ena_o, mem_w_r_o,
         mem_addr_o, mem_data_o, mem_sel_o, stall_o} !== '0) begin
      $display("FAIL reset_mid_outputs: got ena=%b wr=%b addr=%h data=%h sel=%b stall=%b want all 0",
               mem_ena_o, mem_w_r_o, mem_addr_o, mem_data_o, mem_sel_o, stall_o);
      n_bad++;
    end
    tick();
    rst = 1'b1; mem_valid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_o !== 1'b0) got_done = 1'b1;
    end
    mem_valid = 1'b0;
    n_cmp++; if (got_done) begin $display("FAIL reset_late_valid: got done=1 want 0"); n_bad++; end
    tick();
    do_access(MEM_LHU, 32'h2, 32'h0, 32'hBEEF1234, 1, cyc, ecnt, sel_s, addr_s, data_s, wr_s, stall_s, rd_s, fl_s);
    n_cmp++; if (fl_s !== 3'b100 || rd_s !== 32'h0000BEEF || cyc != 3) begin
      $display("FAIL reset_recover: got %b/%h cycles=%0d want 100/0000beef/3", fl_s, rd_s, cyc); n_bad++; end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sb();
    test_sh_sw();
    test_loads();
    test_misalign_noop();
    test_timeout();
    test_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
